// File: rtl/truth_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// truth_sweep_ctrl
//
// Sweep sequencer for a mux-based truth-table evaluator. It walks the select
// bus through every code. On each code it waits SETTLE cycles, then samples
// the evaluator output into a captured table. It also counts the bits of that
// table that disagree with a golden pattern. At the end of the sweep it reports
// the result with a one-cycle done pulse, a match flag and an error count.
//
// Parameters
//   SEL_W      select bus width; the table has 2**SEL_W entries
//   SETTLE     wait cycles on each code before sampling (0 allowed)
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset; aborts any sweep in progress
//   inStart    sweep request, only looked at while idle
//   inY        evaluator output for the code currently on outS
//   inExpected golden table, bit i = expected inY at select i
//   outS       select code driven to the evaluator
//   outTable   captured table, bit i = inY sampled at code i
//   outBusy    high from the cycle after accept through the last sample
//   outDone    one-cycle pulse when the sweep completes
//   outMatch   captured table equals golden; valid from outDone until next accept
//   outErrors  number of differing bits; valid together with outMatch
//
// Every output is taken directly from a register. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module truth_sweep_ctrl #(
   parameter int SEL_W  = 3,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inStart,
   input  logic                  inY,
   input  logic [2**SEL_W-1:0]   inExpected,
   output logic [SEL_W-1:0]      outS,
   output logic [2**SEL_W-1:0]   outTable,
   output logic                  outBusy,
   output logic                  outDone,
   output logic                  outMatch,
   output logic [SEL_W:0]        outErrors
);

   localparam int N_CODES = 2**SEL_W;
   // The counter only has to hold SETTLE. Keep at least one bit so that
   // SETTLE=0 still elaborates.
   localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
   localparam logic [SEL_W-1:0] LAST_CODE = SEL_W'(N_CODES - 1);
   localparam logic             HAS_WAIT  = (SETTLE > 0) ? 1'b1 : 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [SEL_W-1:0]      r_s;
   logic [N_CODES-1:0]    r_table;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_match;
   logic [SEL_W:0]        r_errors;

   logic                  w_exp_bit;
   logic                  w_miss;
   logic [SEL_W:0]        w_err_next;
   logic                  w_last_code;
   logic                  w_settle_end;
   state_t                w_after_load;

   // Per-sample compare and next-count helpers for the current select code
   always_comb begin
      w_exp_bit    = inExpected[r_s];
      w_miss       = inY ^ w_exp_bit;
      // At most 2**SEL_W misses are possible, so SEL_W+1 bits cannot overflow.
      w_err_next   = r_errors + (SEL_W+1)'(w_miss);
      w_last_code  = (r_s == LAST_CODE);
      // A count of 1 is the final settle cycle. The count cannot be 0 here,
      // but it is treated the same way so that a bad count cannot stall.
      w_settle_end = (r_cnt <= CNT_W'(1));
      if (HAS_WAIT) begin
         w_after_load = ST_SETTLE;
      end else begin
         w_after_load = ST_SAMPLE;
      end
   end

   // Sweep FSM together with all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_s      <= '0;
         r_table  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_match  <= 1'b0;
         r_errors <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (inStart) begin
                  r_s      <= '0;
                  r_table  <= '0;
                  r_errors <= '0;
                  r_match  <= 1'b0;
                  r_cnt    <= SETTLE_LD;
                  r_busy   <= 1'b1;
                  r_state  <= w_after_load;
               end else begin
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end

            ST_SETTLE: begin
               if (w_settle_end) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_state <= ST_SETTLE;
               end
            end

            ST_SAMPLE: begin
               r_table[r_s] <= inY;
               r_errors     <= w_err_next;
               if (w_last_code) begin
                  // outS stays on the last code. The match flag uses the
                  // count that already includes this final sample, so it is
                  // valid in the same cycle as outDone.
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_match <= (w_err_next == '0);
                  r_state <= ST_DONE;
               end else begin
                  r_s     <= r_s + SEL_W'(1);
                  r_cnt   <= SETTLE_LD;
                  r_state <= w_after_load;
               end
            end

            ST_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign outS      = r_s;
   assign outTable  = r_table;
   assign outBusy   = r_busy;
   assign outDone   = r_done;
   assign outMatch  = r_match;
   assign outErrors = r_errors;

endmodule
